// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multicycle LEGv8 control FSM. It sequences the shared ALU, the
//            register file, PC/IR and a unified memory port over several
//            cycles per instruction. Decoded subset: LDUR, STUR, CBZ, CBNZ,
//            ADD, SUB, AND, ORR, ADDI. Memory accesses use a req/ready
//            handshake with a timeout, and retired instructions are counted.
// Ports    : clk        - sole clock, rising edge
//            reset      - asynchronous active-low reset (0 = reset)
//            Op         - opcode Instr[31:21] from IR, valid from DECODE on
//            Zero       - ALU zero flag
//            mem_ready  - memory completes the current access this cycle
//            mem_req/MemRead/MemWrite/IorD - memory port controls
//            IRWrite/PCWrite/PCSrc         - IR and PC controls
//            Reg2Loc/RegWrite/MemtoReg     - register file controls
//            ALUSrcA/ALUSrcB/ALUOp         - ALU operand and op selects
//            halted     - FSM is in HALT
//            fault      - 00 none, 01 illegal opcode, 10 memory timeout
//            retired    - retired-instruction count (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      Op,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             Reg2Loc,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADDR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ILL, C_LDUR, C_STUR, C_CBZ, C_CBNZ, C_RTYPE, C_ADDI
  } cls_t;

  state_t             state_q, state_d;
  cls_t               cls_q, cls_d, cls_dec;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [1:0]         fault_q, fault_d;
  logic [CNT_W-1:0]   retired_q;
  logic               retire;
  logic               wait_state;
  logic               timed_out;

  // Opcode classification of the live IR opcode.
  always_comb begin
    cls_dec = C_ILL;
    casez (Op)
      11'b11111000010: cls_dec = C_LDUR;
      11'b11111000000: cls_dec = C_STUR;
      11'b10110100???: cls_dec = C_CBZ;
      11'b10110101???: cls_dec = C_CBNZ;
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: cls_dec = C_RTYPE;
      11'b1001000100?: cls_dec = C_ADDI;
      default:         cls_dec = C_ILL;
    endcase
  end

  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                      (state_q == S_MEMWR);
  assign timed_out  = (wait_q == WAIT_MAX);

  // Next state and Moore outputs.
  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    fault_d  = fault_q;
    retire   = 1'b0;
    mem_req  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    Reg2Loc  = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    halted   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          // PC <= PC+4 happens in the same cycle the instruction arrives.
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_HALT;
          fault_d = 2'b10;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while decoding.
        ALUSrcB = 2'b11;
        cls_d   = cls_dec;
        Reg2Loc = (cls_dec == C_STUR) || (cls_dec == C_CBZ) ||
                  (cls_dec == C_CBNZ);
        case (cls_dec)
          C_LDUR, C_STUR: state_d = S_MEMADDR;
          C_RTYPE:        state_d = S_EXEC_R;
          C_ADDI:         state_d = S_EXEC_I;
          C_CBZ, C_CBNZ:  state_d = S_BRANCH;
          default: begin
            state_d = S_HALT;
            fault_d = 2'b01;
          end
        endcase
      end
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        Reg2Loc = (cls_q == C_STUR);
        state_d = (cls_q == C_STUR) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timed_out) begin
          state_d = S_HALT;
          fault_d = 2'b10;
        end
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        Reg2Loc  = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (timed_out) begin
          state_d = S_HALT;
          fault_d = 2'b10;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        Reg2Loc = 1'b1;
        PCSrc   = 1'b1;
        PCWrite = ((cls_q == C_CBZ) && Zero) || ((cls_q == C_CBNZ) && !Zero);
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // The state register resets to FETCH, whose outputs would otherwise
    // request memory; hold every strobe low for as long as reset is low.
    if (!reset) begin
      mem_req  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 1'b0;
      Reg2Loc  = 1'b0;
      RegWrite = 1'b0;
      MemtoReg = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ALUOp    = 2'b00;
      halted   = 1'b0;
    end
  end

  // Counter runs only while a wait state repeats; any state change (entry,
  // accepted mem_ready, timeout) restarts it from zero.
  always_comb begin
    wait_d = '0;
    if (wait_state && (state_d == state_q)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      cls_q     <= C_ILL;
      wait_q    <= '0;
      fault_q   <= 2'b00;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign fault   = fault_q;
  assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Directed self-checking bench for multicycle_ctrl, built with a
//            short timeout and a narrow retired counter so the timeout and
//            wrap boundaries are reachable quickly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  // Packed view of the control outputs:
  // {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc, Reg2Loc,
  //  RegWrite, MemtoReg, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], halted, fault[1:0]}
  localparam logic [17:0] MREQ   = 18'd1 << 17;
  localparam logic [17:0] MRD    = 18'd1 << 16;
  localparam logic [17:0] MWR    = 18'd1 << 15;
  localparam logic [17:0] IORD   = 18'd1 << 14;
  localparam logic [17:0] IRW    = 18'd1 << 13;
  localparam logic [17:0] PCW    = 18'd1 << 12;
  localparam logic [17:0] PCS    = 18'd1 << 11;
  localparam logic [17:0] R2L    = 18'd1 << 10;
  localparam logic [17:0] RW     = 18'd1 << 9;
  localparam logic [17:0] M2R    = 18'd1 << 8;
  localparam logic [17:0] SA     = 18'd1 << 7;
  localparam logic [17:0] SB4    = 18'd1 << 5;
  localparam logic [17:0] SBI    = 18'd2 << 5;
  localparam logic [17:0] SBBR   = 18'd3 << 5;
  localparam logic [17:0] OPCMP  = 18'd1 << 3;
  localparam logic [17:0] OPFN   = 18'd2 << 3;
  localparam logic [17:0] HLT    = 18'd1 << 2;
  localparam logic [17:0] F_ILL  = 18'd1;
  localparam logic [17:0] F_TO   = 18'd2;

  localparam logic [17:0] FETCH_WAIT = MREQ | MRD | SB4;
  localparam logic [17:0] FETCH_GO   = FETCH_WAIT | IRW | PCW;
  localparam logic [17:0] DEC        = SBBR;
  localparam logic [17:0] MEMADDR    = SA | SBI;
  localparam logic [17:0] MEMRD      = MREQ | MRD | IORD;
  localparam logic [17:0] MEMWB      = RW | M2R;
  localparam logic [17:0] MEMWR      = MREQ | MWR | IORD | R2L;
  localparam logic [17:0] EXEC_R     = SA | OPFN;
  localparam logic [17:0] EXEC_I     = SA | SBI | OPFN;
  localparam logic [17:0] ALUWB      = RW;
  localparam logic [17:0] BRANCH     = SA | OPCMP | R2L | PCS;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   Op;
  logic          Zero;
  logic          mem_ready;
  logic          mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc;
  logic          Reg2Loc, RegWrite, MemtoReg, ALUSrcA, halted;
  logic [1:0]    ALUSrcB, ALUOp, fault;
  logic [CW-1:0] retired;

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [CW-1:0] exp_ret  = '0;

  logic [17:0]   exp_q[$];
  string         tag_q[$];
  logic [17:0]   obs;

  assign obs = {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc,
                Reg2Loc, RegWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUOp,
                halted, fault};

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Zero      (Zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .IorD      (IorD),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .PCSrc     (PCSrc),
    .Reg2Loc   (Reg2Loc),
    .RegWrite  (RegWrite),
    .MemtoReg  (MemtoReg),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .halted    (halted),
    .fault     (fault),
    .retired   (retired)
  );

  task automatic compare_next();
    logic [17:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  // One clock cycle: drive inputs, queue the expected outputs, compare once
  // settled mid-cycle, then advance to just after the next rising edge.
  task automatic cyc(input logic rdy, input logic z, input logic [17:0] e,
                     input string tag);
    mem_ready = rdy;
    Zero      = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #2;
    compare_next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ret(input string tag);
    n_assert++;
    assert (retired === exp_ret) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, retired, exp_ret);
    end
  endtask

  task automatic alu_instr(input logic [10:0] op, input logic [17:0] ex,
                           input string tag);
    Op = op;
    cyc(1'b1, 1'b0, FETCH_GO, {tag, "_fetch"});
    cyc(1'b1, 1'b0, DEC,      {tag, "_decode"});
    cyc(1'b1, 1'b0, ex,       {tag, "_exec"});
    cyc(1'b1, 1'b0, ALUWB,    {tag, "_wb"});
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic branch_instr(input logic [10:0] op, input logic z,
                              input logic taken, input string tag);
    Op = op;
    cyc(1'b1, z, FETCH_GO, {tag, "_fetch"});
    cyc(1'b1, z, DEC | R2L, {tag, "_decode"});
    cyc(1'b1, z, taken ? (BRANCH | PCW) : BRANCH, {tag, "_branch"});
    exp_ret = exp_ret + 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    mem_ready = 1'b1;
    Zero      = 1'b0;
    Op        = 11'h000;
    #1;
    // Reset held low across an edge: no strobes, counters clear.
    cyc(1'b1, 1'b0, 18'd0, "reset_outputs");
    chk_ret("reset_retired");
    reset = 1'b1;

    // ADD with zero-wait memory.
    alu_instr(11'h458, EXEC_R, "add");
    chk_ret("add_retired");

    // LDUR with three wait cycles on the data read.
    Op = 11'h7C2;
    cyc(1'b1, 1'b0, FETCH_GO, "ldur_fetch");
    cyc(1'b1, 1'b0, DEC,      "ldur_decode");
    cyc(1'b1, 1'b0, MEMADDR,  "ldur_memaddr");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, MEMRD, "ldur_memrd_wait");
    cyc(1'b1, 1'b0, MEMRD,    "ldur_memrd_done");
    cyc(1'b1, 1'b0, MEMWB,    "ldur_memwb");
    exp_ret = exp_ret + 1'b1;
    chk_ret("ldur_retired");

    // Branches: CBZ taken, CBNZ not taken, both with Zero = 1.
    branch_instr(11'h5A0, 1'b1, 1'b1, "cbz_z1");
    branch_instr(11'h5A8, 1'b1, 1'b0, "cbnz_z1");
    chk_ret("branch_retired");
    branch_instr(11'h5AF, 1'b0, 1'b1, "cbnz_z0");

    // Immediate and other R-type encodings.
    alu_instr(11'h489, EXEC_I, "addi");
    alu_instr(11'h658, EXEC_R, "sub");
    alu_instr(11'h550, EXEC_R, "orr");
    chk_ret("alu_retired");

    // STUR: fetch stalls once, write completes on the last allowed cycle.
    Op = 11'h7C0;
    cyc(1'b0, 1'b0, FETCH_WAIT,    "stur_fetch_wait");
    cyc(1'b1, 1'b0, FETCH_GO,      "stur_fetch");
    cyc(1'b1, 1'b0, DEC | R2L,     "stur_decode");
    cyc(1'b1, 1'b0, MEMADDR | R2L, "stur_memaddr");
    for (int i = 0; i < TO - 1; i++) cyc(1'b0, 1'b0, MEMWR, "stur_memwr_wait");
    cyc(1'b1, 1'b0, MEMWR,         "stur_memwr_last");
    exp_ret = exp_ret + 1'b1;
    chk_ret("stur_retired");

    // STUR whose write never completes -> timeout fault.
    cyc(1'b1, 1'b0, FETCH_GO,      "sturto_fetch");
    cyc(1'b1, 1'b0, DEC | R2L,     "sturto_decode");
    cyc(1'b1, 1'b0, MEMADDR | R2L, "sturto_memaddr");
    for (int i = 0; i < TO; i++) cyc(1'b0, 1'b0, MEMWR, "sturto_memwr_wait");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, HLT | F_TO, "timeout_halt");
    chk_ret("timeout_retired");

    // Only reset leaves HALT.
    reset = 1'b0;
    cyc(1'b1, 1'b0, 18'd0, "halt_reset");
    exp_ret = '0;
    chk_ret("halt_reset_retired");
    reset = 1'b1;

    // Illegal opcode after one retire: sticky HALT, retired frozen.
    alu_instr(11'h450, EXEC_R, "and");
    Op = 11'h000;
    cyc(1'b1, 1'b0, FETCH_GO, "ill_fetch");
    cyc(1'b1, 1'b0, DEC,      "ill_decode");
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, HLT | F_ILL, "ill_halt");
    chk_ret("ill_retired");

    reset = 1'b0;
    cyc(1'b1, 1'b0, 18'd0, "ill_reset");
    exp_ret = '0;
    reset = 1'b1;

    // Reset asserted in the middle of a write access.
    Op = 11'h7C0;
    cyc(1'b1, 1'b0, FETCH_GO,      "abort_fetch");
    cyc(1'b1, 1'b0, DEC | R2L,     "abort_decode");
    cyc(1'b1, 1'b0, MEMADDR | R2L, "abort_memaddr");
    cyc(1'b0, 1'b0, MEMWR,         "abort_memwr");
    mem_ready = 1'b1;
    #1;
    reset = 1'b0;
    cyc(1'b1, 1'b0, 18'd0, "abort_reset_outputs");
    chk_ret("abort_retired");
    reset = 1'b1;
    cyc(1'b1, 1'b0, FETCH_GO,      "abort_refetch");
    cyc(1'b1, 1'b0, DEC | R2L,     "abort_redecode");
    cyc(1'b1, 1'b0, MEMADDR | R2L, "abort_rememaddr");
    cyc(1'b1, 1'b0, MEMWR,         "abort_rememwr");
    exp_ret = exp_ret + 1'b1;

    // Drive the 4-bit retired counter to 15, then wrap it.
    while (exp_ret != 4'd15) branch_instr(11'h5A0, 1'b0, 1'b0, "cbz_nt");
    chk_ret("retired_15");
    branch_instr(11'h5A0, 1'b0, 1'b0, "cbz_wrap");
    chk_ret("retired_wrap");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle LEGv8 control FSM. Sequences the shared ALU, register file, PC/IR and unified memory port over several cycles per instruction.
- Decodes the same instruction subset as the single-cycle decoder: LDUR, STUR, CBZ, CBNZ, ADD, SUB, AND, ORR, ADDI.
- Performs a req/ready handshake with memory, times out stalled accesses, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 16, max cycles a memory access may wait for mem_ready before fault; must be >=2.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk, input, 1, sole clock; all state changes on rising edge.
- reset, input, 1, asynchronous active-low reset (0 = reset).
- Op, input, 11, opcode Instr[31:21] from instruction register; valid from DECODE onward.
- Zero, input, 1, ALU zero flag.
- mem_ready, input, 1, memory completes current access this cycle.
- mem_req, output, 1, memory access request.
- MemRead, output, 1, read strobe.
- MemWrite, output, 1, write strobe.
- IorD, output, 1, address mux: 0 = PC, 1 = ALUOut.
- IRWrite, output, 1, load instruction register.
- PCWrite, output, 1, load PC.
- PCSrc, output, 1, PC mux: 0 = ALU result (PC+4), 1 = ALUOut (branch target).
- Reg2Loc, output, 1, read-reg-2 select: 1 = Rt.
- RegWrite, output, 1, regfile write.
- MemtoReg, output, 1, writeback mux: 1 = MDR.
- ALUSrcA, output, 1, 0 = PC, 1 = reg A.
- ALUSrcB, output, 2, 00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = branch offset << 2.
- ALUOp, output, 2, 00 = add, 01 = pass-B/compare, 10 = funct decode.
- halted, output, 1, FSM in HALT.
- fault, output, 2, 00 = none, 01 = illegal opcode, 10 = memory timeout.
- retired, output, CNT_W, retired-instruction count.

Behaviour:
- States: FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, HALT.
- Outputs are Moore functions of state, registered opcode class and Zero. Any output not listed for a state is 0.
- While reset = 0:
  - state forced to FETCH; wait counter, opcode class, fault and retired are cleared;
  - every output is forced to 0, so no mem_req is issued during reset.
- FETCH:
  - Outputs: mem_req = 1, MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00.
  - When mem_ready = 1 in the same cycle, also IRWrite = 1, PCWrite = 1, PCSrc = 0; next state DECODE. Otherwise stay in FETCH.
- DECODE:
  - Latches opcode class from Op: LDUR 7C2, STUR 7C0, CBZ 10110100xxx, CBNZ 10110101xxx, R-type 458/658/450/550, ADDI 1001000100x. Anything else is illegal.
  - Outputs: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target into ALUOut); Reg2Loc = 1 for STUR/CBZ/CBNZ.
  - Next state: LDUR/STUR -> MEMADDR; R -> EXEC_R; ADDI -> EXEC_I; CBZ/CBNZ -> BRANCH; illegal -> HALT with fault = 01.
- MEMADDR:
  - Outputs: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00; Reg2Loc = 1 if STUR.
  - Next state: MEMRD for LDUR, MEMWR for STUR.
- MEMRD: mem_req = 1, MemRead = 1, IorD = 1; wait for mem_ready, then MEMWB.
- MEMWB: RegWrite = 1, MemtoReg = 1; next FETCH; instruction retires.
- MEMWR: mem_req = 1, MemWrite = 1, IorD = 1, Reg2Loc = 1; on mem_ready go to FETCH and retire.
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10; next ALUWB.
- EXEC_I: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 10; next ALUWB.
- ALUWB: RegWrite = 1, MemtoReg = 0; next FETCH; retire.
- BRANCH:
  - Outputs: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, Reg2Loc = 1, PCSrc = 1.
  - PCWrite = (CBZ & Zero) | (CBNZ & ~Zero).
  - Next FETCH; retire whether or not the branch is taken.
- Instruction latency with zero-wait memory:
  - LDUR 5 cycles;
  - STUR, R-type, ADDI 4 cycles;
  - CBZ/CBNZ 3 cycles.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD and MEMWR, and on every accepted mem_ready.
  - Increments each cycle in those states while mem_ready = 0.
  - If the counter reaches MEM_TIMEOUT-1 with mem_ready = 0, next state is HALT with fault = 10. mem_ready arriving on that same cycle wins: the access completes and there is no fault.
- retired:
  - Increments by 1 on the cycle of the retiring transition.
  - Wraps modulo 2^CNT_W with no flag.
- HALT:
  - Sticky: all strobes 0, halted = 1, fault held.
  - Only reset exits HALT.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Reset asserted mid-instruction (including mid-access) aborts the instruction. No further writes occur; retired is not incremented.

Test Plan:
- Reset then ADD (Op = 458), mem_ready tied 1 -> FETCH, DECODE, EXEC_R, ALUWB. RegWrite = 1 only in cycle 4, ALUOp = 10 in EXEC_R. retired 0 -> 1.
- LDUR (7C2) with MEMRD ready delayed 3 cycles -> mem_req held with IorD = 1 for 4 cycles. MEMWB shows RegWrite = 1, MemtoReg = 1. Total latency 8 cycles.
- CBZ (5A0) with Zero = 1, then CBNZ (5A8) with Zero = 1 -> first BRANCH: PCWrite = 1, PCSrc = 1. Second BRANCH: PCWrite = 0. retired +2.
- Op = 000 (illegal) -> HALT after DECODE, fault = 01, halted = 1. No strobes for 20 cycles despite mem_ready = 1; retired unchanged.
- MEM_TIMEOUT = 4, STUR with mem_ready held 0 -> MEMWR for 4 cycles, then HALT, fault = 10. Repeat with ready on the 4th cycle -> no fault, returns to FETCH.
- Reset pulsed low during MEMWR, and CNT_W = 4 after 15 retires -> all outputs 0 immediately, FETCH after release. Retiring 16 instructions wraps retired to 0.
